// File: rtl/bt656_capture.sv
// BT.656 line capture: finds FF 00 00 XY timing codes, tracks V/F, and packs
// active-line bytes into 16-bit words for a line FIFO.
module bt656_capture #(
   parameter int ACTIVE_WORDS = 720,
   parameter bit CHECK_PROT   = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  vid_data,
   input  logic        fifo_full,
   output logic        fifo_wr_en,
   output logic [15:0] fifo_wr_data,
   output logic        vs,
   output logic        vs_neg,
   output logic        field,
   output logic [9:0]  line_cnt,
   output logic        overflow,
   output logic        prot_err
);

   localparam int CW = (ACTIVE_WORDS > 1) ? $clog2(ACTIVE_WORDS) : 1;

   typedef enum logic [2:0] {
      S_SRCH = 3'd0,
      S_FF   = 3'd1,
      S_Z1   = 3'd2,
      S_Z2   = 3'd3,
      S_ACT  = 3'd4
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;

   logic          r_phase;
   logic [7:0]    r_hi;
   logic [CW-1:0] r_word_cnt;
   logic          r_wr_en;
   logic [15:0]   r_wr_data;
   logic          r_vs;
   logic          r_vs_neg;
   logic          r_field;
   logic [9:0]    r_line_cnt;
   logic          r_overflow;
   logic          r_prot_err;

   logic          w_phase_nxt;
   logic [7:0]    w_hi_nxt;
   logic [CW-1:0] w_word_cnt_nxt;
   logic          w_wr_en_nxt;
   logic [15:0]   w_wr_data_nxt;
   logic          w_vs_nxt;
   logic          w_vs_neg_nxt;
   logic          w_field_nxt;
   logic [9:0]    w_line_cnt_nxt;
   logic          w_overflow_nxt;
   logic          w_prot_err_nxt;

   logic          w_f;
   logic          w_v;
   logic          w_h;
   logic          w_is_ff;
   logic          w_prot_ok;
   logic          w_xy_ok;
   logic          w_sav;
   logic          w_last_word;

   assign w_f         = vid_data[6];
   assign w_v         = vid_data[5];
   assign w_h         = vid_data[4];
   assign w_is_ff     = (vid_data == 8'hFF);
   assign w_prot_ok   = (vid_data[3:0] == {w_v ^ w_h, w_f ^ w_h, w_f ^ w_v, w_f ^ w_v ^ w_h});
   assign w_xy_ok     = vid_data[7] & (w_prot_ok | ~CHECK_PROT);
   assign w_sav       = w_xy_ok & ~w_h & ~w_v;
   assign w_last_word = (r_word_cnt == CW'(ACTIVE_WORDS - 1));

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_SRCH;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode: preamble search, XY decode, active-line byte pairing
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_SRCH: begin
            if (w_is_ff) w_state_nxt = S_FF;
            else         w_state_nxt = S_SRCH;
         end
         S_FF: begin
            if (vid_data == 8'h00) w_state_nxt = S_Z1;
            else if (w_is_ff)      w_state_nxt = S_FF;
            else                   w_state_nxt = S_SRCH;
         end
         S_Z1: begin
            if (vid_data == 8'h00) w_state_nxt = S_Z2;
            else if (w_is_ff)      w_state_nxt = S_FF;
            else                   w_state_nxt = S_SRCH;
         end
         S_Z2: begin
            if (w_sav) w_state_nxt = S_ACT;
            else       w_state_nxt = S_SRCH;
         end
         S_ACT: begin
            if (w_is_ff)                    w_state_nxt = S_FF;
            else if (r_phase && w_last_word) w_state_nxt = S_SRCH;
            else                            w_state_nxt = S_ACT;
         end
         default: w_state_nxt = S_SRCH;
      endcase
   end

   // Output/datapath decode; vs_neg and the line counter clear share the XY edge
   always_comb begin
      w_phase_nxt    = r_phase;
      w_hi_nxt       = r_hi;
      w_word_cnt_nxt = r_word_cnt;
      w_wr_en_nxt    = 1'b0;
      w_wr_data_nxt  = r_wr_data;
      w_vs_nxt       = r_vs;
      w_vs_neg_nxt   = 1'b0;
      w_field_nxt    = r_field;
      w_line_cnt_nxt = r_line_cnt;
      w_overflow_nxt = r_overflow;
      w_prot_err_nxt = 1'b0;
      case (r_state)
         S_Z2: begin
            if (w_xy_ok) begin
               w_vs_nxt       = w_v;
               w_field_nxt    = w_f;
               w_vs_neg_nxt   = r_vs & ~w_v;
               w_phase_nxt    = 1'b0;
               w_word_cnt_nxt = '0;
               if (r_vs && !w_v) w_line_cnt_nxt = 10'd0;
               else              w_line_cnt_nxt = r_line_cnt;
            end else begin
               w_prot_err_nxt = 1'b1;
            end
         end
         S_ACT: begin
            if (w_is_ff) begin
               w_phase_nxt = 1'b0;
            end else if (!r_phase) begin
               w_hi_nxt    = vid_data;
               w_phase_nxt = 1'b1;
            end else begin
               w_phase_nxt    = 1'b0;
               w_word_cnt_nxt = r_word_cnt + CW'(1);
               if (fifo_full) begin
                  w_overflow_nxt = 1'b1;
               end else begin
                  w_wr_en_nxt   = 1'b1;
                  w_wr_data_nxt = {r_hi, vid_data};
               end
               if (w_last_word && (r_line_cnt != 10'd1023)) w_line_cnt_nxt = r_line_cnt + 10'd1;
               else                                         w_line_cnt_nxt = r_line_cnt;
            end
         end
         default: begin
            w_phase_nxt = r_phase;
         end
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_phase    <= 1'b0;
         r_hi       <= 8'h00;
         r_word_cnt <= '0;
         r_wr_en    <= 1'b0;
         r_wr_data  <= 16'h0000;
         r_vs       <= 1'b1;
         r_vs_neg   <= 1'b0;
         r_field    <= 1'b0;
         r_line_cnt <= 10'd0;
         r_overflow <= 1'b0;
         r_prot_err <= 1'b0;
      end else begin
         r_phase    <= w_phase_nxt;
         r_hi       <= w_hi_nxt;
         r_word_cnt <= w_word_cnt_nxt;
         r_wr_en    <= w_wr_en_nxt;
         r_wr_data  <= w_wr_data_nxt;
         r_vs       <= w_vs_nxt;
         r_vs_neg   <= w_vs_neg_nxt;
         r_field    <= w_field_nxt;
         r_line_cnt <= w_line_cnt_nxt;
         r_overflow <= w_overflow_nxt;
         r_prot_err <= w_prot_err_nxt;
      end
   end

   assign fifo_wr_en   = r_wr_en;
   assign fifo_wr_data = r_wr_data;
   assign vs           = r_vs;
   assign vs_neg       = r_vs_neg;
   assign field        = r_field;
   assign line_cnt     = r_line_cnt;
   assign overflow     = r_overflow;
   assign prot_err     = r_prot_err;

endmodule

// File: tb/tb_bt656_capture.sv
// Directed bench for bt656_capture: expected FIFO words go into a queue that a
// forked monitor drains on every write strobe.
module tb_bt656_capture;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  vid_data;
   logic        fifo_full;
   logic        fifo_wr_en;
   logic [15:0] fifo_wr_data;
   logic        vs;
   logic        vs_neg;
   logic        field;
   logic [9:0]  line_cnt;
   logic        overflow;
   logic        prot_err;

   int          total = 0;
   int          bad   = 0;
   int          n_wr  = 0;
   int          base  = 0;
   logic [15:0] exp_q[$];

   bt656_capture #(.ACTIVE_WORDS(720), .CHECK_PROT(1'b1)) dut (
      .clk          (clk),
      .reset        (reset),
      .vid_data     (vid_data),
      .fifo_full    (fifo_full),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_wr_data (fifo_wr_data),
      .vs           (vs),
      .vs_neg       (vs_neg),
      .field        (field),
      .line_cnt     (line_cnt),
      .overflow     (overflow),
      .prot_err     (prot_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // one byte per rising edge; returns just after that edge
   task automatic put(input logic [7:0] b);
      vid_data = b;
      @(posedge clk);
      #1;
   endtask

   task automatic send_code(input logic [7:0] xy);
      put(8'hFF);
      put(8'h00);
      put(8'h00);
      put(xy);
   endtask

   task automatic send_pairs(input int first, input int n, input int full_lo, input int full_hi);
      logic [7:0] hi;
      logic [7:0] lo;
      for (int w = first; w < first + n; w++) begin
         hi = (w % 2 == 0) ? 8'h10 : 8'h30;
         lo = (w % 2 == 0) ? 8'h20 : 8'h40;
         fifo_full = (w >= full_lo) && (w < full_hi);
         put(hi);
         if (!fifo_full) exp_q.push_back({hi, lo});
         put(lo);
      end
      fifo_full = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_wr_en"},    {31'd0, fifo_wr_en}, 32'd0);
      chk({tag, "_wr_data"},  {16'd0, fifo_wr_data}, 32'd0);
      chk({tag, "_vs"},       {31'd0, vs}, 32'd1);
      chk({tag, "_vs_neg"},   {31'd0, vs_neg}, 32'd0);
      chk({tag, "_field"},    {31'd0, field}, 32'd0);
      chk({tag, "_line_cnt"}, {22'd0, line_cnt}, 32'd0);
      chk({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
      chk({tag, "_prot_err"}, {31'd0, prot_err}, 32'd0);
   endtask

   initial begin
      reset     = 1'b1;
      vid_data  = 8'h00;
      fifo_full = 1'b0;

      fork
         forever begin
            @(negedge clk);
            if (fifo_wr_en === 1'b1) begin
               n_wr++;
               total++;
               if (exp_q.size() == 0) begin
                  bad++;
                  $display("FAIL unexpected_write: got %0h expected none", fifo_wr_data);
               end else if (fifo_wr_data !== exp_q[0]) begin
                  bad++;
                  $display("FAIL wr_data: got %0h expected %0h", fifo_wr_data, exp_q[0]);
                  void'(exp_q.pop_front());
               end else begin
                  void'(exp_q.pop_front());
               end
            end
         end
      join_none

      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("rst");
      reset = 1'b0;

      // vertical blanking EAV then active-region EAV
      send_code(8'hB6);
      chk("eav_v1_vs", {31'd0, vs}, 32'd1);
      chk("eav_v1_vs_neg", {31'd0, vs_neg}, 32'd0);
      send_code(8'h9D);
      chk("eav_v0_vs", {31'd0, vs}, 32'd0);
      chk("eav_v0_vs_neg", {31'd0, vs_neg}, 32'd1);
      chk("eav_v0_line_cnt", {22'd0, line_cnt}, 32'd0);
      put(8'h00);
      chk("vs_neg_one_cycle", {31'd0, vs_neg}, 32'd0);

      // full line, with first-strobe latency check
      base = n_wr;
      send_code(8'h80);
      exp_q.push_back(16'h1020);
      put(8'h10);
      chk("lat_after_cb", {31'd0, fifo_wr_en}, 32'd0);
      put(8'h20);
      chk("lat_after_y0", {31'd0, fifo_wr_en}, 32'd1);
      send_pairs(1, 719, 0, 0);
      put(8'h00);
      chk("line1_writes", n_wr - base, 32'd720);
      chk("line1_line_cnt", {22'd0, line_cnt}, 32'd1);

      // FIFO full for three word slots
      chk("ovf_before", {31'd0, overflow}, 32'd0);
      base = n_wr;
      send_code(8'h80);
      send_pairs(0, 720, 200, 203);
      put(8'h00);
      chk("line2_writes", n_wr - base, 32'd717);
      chk("line2_overflow", {31'd0, overflow}, 32'd1);
      chk("line2_line_cnt", {22'd0, line_cnt}, 32'd2);

      // SAV interrupted by a code with bad protection bits
      base = n_wr;
      send_code(8'h80);
      send_code(8'h81);
      chk("prot_err_pulse", {31'd0, prot_err}, 32'd1);
      chk("prot_vs_kept", {31'd0, vs}, 32'd0);
      put(8'h10);
      chk("prot_err_clear", {31'd0, prot_err}, 32'd0);
      put(8'h20);
      put(8'h30);
      put(8'h40);
      chk("prot_no_writes", n_wr - base, 32'd0);

      // abort after 100 words plus a dangling byte; next code still decoded
      base = n_wr;
      send_code(8'h80);
      send_pairs(0, 100, 0, 0);
      put(8'h10);
      send_code(8'hF1);
      chk("abort_writes", n_wr - base, 32'd100);
      chk("abort_line_cnt", {22'd0, line_cnt}, 32'd2);
      chk("abort_next_field", {31'd0, field}, 32'd1);
      chk("abort_next_vs", {31'd0, vs}, 32'd1);

      // leaving vertical blanking clears a non-zero line count
      send_code(8'h9D);
      chk("clr_vs_neg", {31'd0, vs_neg}, 32'd1);
      chk("clr_line_cnt", {22'd0, line_cnt}, 32'd0);
      chk("clr_field", {31'd0, field}, 32'd0);
      chk("ovf_sticky", {31'd0, overflow}, 32'd1);

      // reset in the middle of a line
      base = n_wr;
      send_code(8'h80);
      send_pairs(0, 300, 0, 0);
      reset = 1'b1;
      put(8'h10);
      chk("mid_writes", n_wr - base, 32'd300);
      chk_reset_vals("midrst");
      reset = 1'b0;
      base = n_wr;
      for (int i = 0; i < 8; i++) put((i % 2 == 0) ? 8'h10 : 8'h20);
      chk("post_rst_no_writes", n_wr - base, 32'd0);
      send_code(8'h80);
      send_pairs(0, 2, 0, 0);
      put(8'h00);
      chk("post_rst_new_sav", n_wr - base, 32'd2);

      put(8'h00);
      chk("queue_drained", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
